// File: rtl/capi_unroll_arb_pkg.sv
// Shared constants and helpers for the capi unroll arbiter slice.
// Tag width, default tag FIFO depth and requester slice offsets.
package capi_unroll_arb_pkg;

    localparam int TDEPTH = 4;

    function automatic int tag_w(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

    function automatic int fld_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/capi_unroll_arb_if.sv
// Requester-side and unroll-engine-side handshake bundle.
// slave: the arbiter; master: the surrounding requesters and engine.
interface capi_unroll_arb_if #(
    parameter int n      = 4,
    parameter int width  = 64,
    parameter int cwidth = 4
);
    logic [n-1:0]        req_v;
    logic [n*width-1:0]  req_d;
    logic [n*cwidth-1:0] req_cstart;
    logic [n*cwidth-1:0] req_cend;
    logic [n-1:0]        req_r;
    logic                ur_v;
    logic [width-1:0]    ur_d;
    logic [cwidth-1:0]   ur_cstart;
    logic [cwidth-1:0]   ur_cend;
    logic                ur_r;
    logic                ur_ov;
    logic                ur_oed;
    logic                ur_oacc;

    modport slave (
        input  req_v, req_d, req_cstart, req_cend,
        input  ur_r, ur_ov, ur_oed, ur_oacc,
        output req_r, ur_v, ur_d, ur_cstart, ur_cend
    );

    modport master (
        output req_v, req_d, req_cstart, req_cend,
        output ur_r, ur_ov, ur_oed, ur_oacc,
        input  req_r, ur_v, ur_d, ur_cstart, ur_cend
    );
endinterface

// File: rtl/capi_unroll_tagfifo.sv
// In-flight burst tag FIFO: tdepth x twidth, push/pop/count/full/empty.
// Illegal pushes (full) and pops (empty) are dropped here.
module capi_unroll_tagfifo
    import capi_unroll_arb_pkg::*;
#(
    parameter int tdepth = TDEPTH,
    parameter int twidth = 2,
    localparam int AW    = (tdepth > 1) ? $clog2(tdepth) : 1,
    localparam int CW    = $clog2(tdepth) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [twidth-1:0] tag_i,
    input  logic              pop_i,
    output logic [twidth-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [twidth-1:0] mem_q [tdepth];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CW'(tdepth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < tdepth; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= tag_i;
                wr_q <= (wr_q == AW'(tdepth - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) rd_q <= (rd_q == AW'(tdepth - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/capi_unroll_arb.sv
// Round-robin arbiter feeding the capi unroll engine one descriptor at a time,
// tagging each in-flight burst with its requester for the engine output side.
module capi_unroll_arb
    import capi_unroll_arb_pkg::*;
#(
    parameter int n      = 4,
    parameter int width  = 64,
    parameter int cwidth = 4,
    parameter int tdepth = TDEPTH,
    parameter int twidth = tag_w(n),
    localparam int CW    = $clog2(tdepth) + 1
) (
    input  logic              clk,
    input  logic              reset,
    capi_unroll_arb_if.slave  bus,
    output logic [twidth-1:0] o_tag,
    output logic              o_tagv,
    output logic              o_err
);
    logic [twidth-1:0] ptr_q, ptr_d, gnt_idx;
    logic [twidth:0]   scan;
    logic              gnt_found, gnt_en;
    logic              ur_v_q;
    logic [width-1:0]  ur_d_q;
    logic [cwidth-1:0] ur_cs_q, ur_ce_q;
    logic              err_q, err_d;
    logic              pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt;

    // First valid requester at or after ptr, wrapping explicitly at n.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < n; k++) begin
            scan = {1'b0, ptr_q} + (twidth+1)'(k);
            if (scan >= (twidth+1)'(n)) scan = scan - (twidth+1)'(n);
            if (!gnt_found && bus.req_v[scan[twidth-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[twidth-1:0];
            end
        end
    end

    // Full is judged before any same-cycle pop: no path from ur_oacc to req_r.
    assign gnt_en = ~reset & (~ur_v_q | bus.ur_r) & gnt_found & ~fifo_full;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_en) ptr_d = (gnt_idx == twidth'(n - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign pop   = bus.ur_ov & bus.ur_oacc & bus.ur_oed;
    assign err_d = err_q | (pop & fifo_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            ur_v_q  <= 1'b0;
            ur_d_q  <= '0;
            ur_cs_q <= '0;
            ur_ce_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
            if (gnt_en) begin
                ur_v_q  <= 1'b1;
                ur_d_q  <= bus.req_d[fld_lo(int'(gnt_idx), width) +: width];
                ur_cs_q <= bus.req_cstart[fld_lo(int'(gnt_idx), cwidth) +: cwidth];
                ur_ce_q <= bus.req_cend[fld_lo(int'(gnt_idx), cwidth) +: cwidth];
            end else if (bus.ur_r) begin
                ur_v_q <= 1'b0;
            end
        end
    end

    assign bus.req_r     = gnt_en ? (n'(1) << gnt_idx) : '0;
    assign bus.ur_v      = ur_v_q;
    assign bus.ur_d      = ur_d_q;
    assign bus.ur_cstart = ur_cs_q;
    assign bus.ur_cend   = ur_ce_q;
    assign o_tagv        = (fifo_cnt != '0);
    assign o_err         = err_q;

    capi_unroll_tagfifo #(
        .tdepth (tdepth),
        .twidth (twidth)
    ) u_tagfifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (gnt_en),
        .tag_i   (gnt_idx),
        .pop_i   (pop),
        .head_o  (o_tag),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_capi_unroll_arb.sv
// Scoreboard bench for capi_unroll_arb: expected descriptors and tags are
// queued at grant time and retired when the engine side produces them.
module tb_capi_unroll_arb;

    typedef struct {
        logic [1:0]  tag;
        logic [63:0] d;
        logic [3:0]  cs;
        logic [3:0]  ce;
    } desc_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] o_tag;
    logic       o_tagv;
    logic       o_err;

    logic [63:0] rd  [4];
    logic [3:0]  rcs [4];
    logic [3:0]  rce [4];
    int          seq = 0;
    int          checks = 0;
    int          errors = 0;
    desc_t       exp_desc [$];
    desc_t       exp_tag  [$];

    capi_unroll_arb_if #(.n(4), .width(64), .cwidth(4)) bus ();

    capi_unroll_arb #(
        .n(4), .width(64), .cwidth(4), .tdepth(4), .twidth(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .o_tag  (o_tag),
        .o_tagv (o_tagv),
        .o_err  (o_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.req_d      = '0;
        bus.req_cstart = '0;
        bus.req_cend   = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_d[i*64 +: 64]     = rd[i];
            bus.req_cstart[i*4 +: 4]  = rcs[i];
            bus.req_cend[i*4 +: 4]    = rce[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic renew(input int g);
        seq++;
        rd[g] = {8'(g), 24'h5a5a00, 32'(seq)};
    endtask

    task automatic note_grant(input int g);
        desc_t e;
        e.tag = 2'(g);
        e.d   = rd[g];
        e.cs  = rcs[g];
        e.ce  = rce[g];
        exp_desc.push_back(e);
        exp_tag.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_v = '0;
        bus.ur_r = 1'b0;
        bus.ur_ov = 1'b0;
        bus.ur_oacc = 1'b0;
        bus.ur_oed = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_desc.delete();
        exp_tag.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_v = 4'hf;
        bus.ur_r = 1'b1;
        bus.ur_ov = 1'b1;
        bus.ur_oacc = 1'b1;
        bus.ur_oed = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'h0) begin
            errors++; $display("FAIL rst_req_r got %h want 0", bus.req_r);
        end
        checks++;
        if (bus.ur_v !== 1'b0) begin
            errors++; $display("FAIL rst_ur_v got %b want 0", bus.ur_v);
        end
        checks++;
        if (bus.ur_d !== 64'h0 || bus.ur_cstart !== 4'h0 || bus.ur_cend !== 4'h0) begin
            errors++;
            $display("FAIL rst_ur_desc got %h/%h/%h want 0/0/0",
                     bus.ur_d, bus.ur_cstart, bus.ur_cend);
        end
        checks++;
        if (o_tagv !== 1'b0 || o_tag !== 2'd0) begin
            errors++; $display("FAIL rst_tag got v%b t%0d want v0 t0", o_tagv, o_tag);
        end
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL rst_err got %b want 0", o_err);
        end
    endtask

    task automatic test_single();
        desc_t e, t;
        int beats;
        do_reset();
        renew(1);
        rcs[1] = 4'd2;
        rce[1] = 4'd5;
        bus.req_v = 4'b0010;
        bus.ur_r = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'b0010) begin
            errors++; $display("FAIL single_req_r got %b want 0010", bus.req_r);
        end
        note_grant(1);
        @(posedge clk); #1;
        bus.req_v = '0;
        renew(1);
        @(negedge clk);
        e = exp_desc.pop_front();
        checks++;
        if (bus.ur_v !== 1'b1 || bus.ur_d !== e.d || bus.ur_cstart !== e.cs
            || bus.ur_cend !== e.ce) begin
            errors++;
            $display("FAIL single_ur got v%b %h %0d %0d want v1 %h %0d %0d",
                     bus.ur_v, bus.ur_d, bus.ur_cstart, bus.ur_cend, e.d, e.cs, e.ce);
        end
        checks++;
        if (o_tagv !== 1'b1 || o_tag !== 2'd1) begin
            errors++; $display("FAIL single_tag got v%b t%0d want v1 t1", o_tagv, o_tag);
        end
        while (exp_tag.size() != 0) begin
            t = exp_tag[0];
            beats = int'(4'(t.ce - t.cs)) + 1;
            for (int b = 0; b < beats; b++) begin
                @(posedge clk); #1;
                bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = (b == beats - 1);
                @(negedge clk);
                checks++;
                if (o_tagv !== 1'b1 || o_tag !== t.tag) begin
                    errors++;
                    $display("FAIL single_beat%0d got v%b t%0d want v1 t%0d", b, o_tagv, o_tag, t.tag);
                end
            end
            @(posedge clk); #1;
            bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
            void'(exp_tag.pop_front());
        end
        @(negedge clk);
        checks++;
        if (o_tagv !== 1'b0 || bus.ur_v !== 1'b0) begin
            errors++; $display("FAIL single_drain got tagv%b urv%b want 0 0", o_tagv, bus.ur_v);
        end
    endtask

    task automatic test_back_to_back();
        desc_t e, t;
        int g, beats;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            renew(i); rcs[i] = 4'(i); rce[i] = 4'(i);
        end
        bus.req_v = 4'hf;
        bus.ur_r = 1'b1;
        g = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_r !== 4'(1 << g)) begin
                errors++; $display("FAIL b2b_grant%0d got %b want %b", c, bus.req_r, 4'(1 << g));
            end
            if (c > 0) begin
                e = exp_desc.pop_front();
                checks++;
                if (bus.ur_v !== 1'b1 || bus.ur_d !== e.d) begin
                    errors++; $display("FAIL b2b_ur%0d got v%b %h want v1 %h", c, bus.ur_v, bus.ur_d, e.d);
                end
            end
            note_grant(g);
            @(posedge clk); #1;
            renew(g);
            g = (g + 1) % 4;
        end
        @(negedge clk);
        e = exp_desc.pop_front();
        checks++;
        if (bus.req_r !== 4'h0 || bus.ur_d !== e.d) begin
            errors++; $display("FAIL b2b_full got req_r %b ur_d %h want 0000 %h", bus.req_r, bus.ur_d, e.d);
        end
        checks++;
        if (o_tag !== exp_tag[0].tag) begin
            errors++; $display("FAIL b2b_head got %0d want %0d", o_tag, exp_tag[0].tag);
        end
        @(posedge clk); #1;
        bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'h0 || bus.ur_v !== 1'b0) begin
            errors++; $display("FAIL b2b_popcyc got req_r %b ur_v %b want 0000 0", bus.req_r, bus.ur_v);
        end
        @(posedge clk); #1;
        bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
        void'(exp_tag.pop_front());
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'(1 << g)) begin
            errors++; $display("FAIL b2b_resume got %b want %b", bus.req_r, 4'(1 << g));
        end
        checks++;
        if (o_tagv !== 1'b1 || o_tag !== exp_tag[0].tag) begin
            errors++; $display("FAIL b2b_head2 got v%b t%0d want v1 t%0d", o_tagv, o_tag, exp_tag[0].tag);
        end
        note_grant(g);
        @(posedge clk); #1;
        renew(g);
        bus.req_v = '0;
        @(negedge clk);
        e = exp_desc.pop_front();
        checks++;
        if (bus.ur_v !== 1'b1 || bus.ur_d !== e.d) begin
            errors++; $display("FAIL b2b_ur_resume got v%b %h want v1 %h", bus.ur_v, bus.ur_d, e.d);
        end
        while (exp_tag.size() != 0) begin
            t = exp_tag[0];
            beats = int'(4'(t.ce - t.cs)) + 1;
            for (int b = 0; b < beats; b++) begin
                @(posedge clk); #1;
                bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = (b == beats - 1);
                @(negedge clk);
                checks++;
                if (o_tagv !== 1'b1 || o_tag !== t.tag) begin
                    errors++; $display("FAIL b2b_drain got v%b t%0d want v1 t%0d", o_tagv, o_tag, t.tag);
                end
            end
            @(posedge clk); #1;
            bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
            void'(exp_tag.pop_front());
        end
        @(negedge clk);
        checks++;
        if (o_tagv !== 1'b0) begin
            errors++; $display("FAIL b2b_empty got %b want 0", o_tagv);
        end
    endtask

    task automatic test_stall();
        desc_t e, t;
        int beats;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            renew(i); rcs[i] = 4'd0; rce[i] = 4'd0;
        end
        bus.req_v = 4'b0001;
        bus.ur_r = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'b0001) begin
            errors++; $display("FAIL stall_first got %b want 0001", bus.req_r);
        end
        note_grant(0);
        @(posedge clk); #1;
        renew(0);
        bus.ur_r = 1'b0;
        bus.req_v = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_r !== 4'h0 || bus.ur_v !== 1'b1 || bus.ur_d !== exp_desc[0].d) begin
                errors++;
                $display("FAIL stall_hold%0d got req_r %b v%b %h want 0000 v1 %h",
                         k, bus.req_r, bus.ur_v, bus.ur_d, exp_desc[0].d);
            end
            @(posedge clk); #1;
            if (k == 1) bus.ur_r = 1'b1;
        end
        @(negedge clk);
        e = exp_desc.pop_front();
        checks++;
        if (bus.req_r !== 4'b0010 || bus.ur_d !== e.d) begin
            errors++; $display("FAIL stall_release got req_r %b ur_d %h want 0010 %h", bus.req_r, bus.ur_d, e.d);
        end
        note_grant(1);
        @(posedge clk); #1;
        renew(1);
        bus.req_v = '0;
        @(negedge clk);
        e = exp_desc.pop_front();
        checks++;
        if (bus.ur_v !== 1'b1 || bus.ur_d !== e.d) begin
            errors++; $display("FAIL stall_next got v%b %h want v1 %h", bus.ur_v, bus.ur_d, e.d);
        end
        while (exp_tag.size() != 0) begin
            t = exp_tag[0];
            beats = int'(4'(t.ce - t.cs)) + 1;
            for (int b = 0; b < beats; b++) begin
                @(posedge clk); #1;
                bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = (b == beats - 1);
                @(negedge clk);
                checks++;
                if (o_tagv !== 1'b1 || o_tag !== t.tag) begin
                    errors++; $display("FAIL stall_drain got v%b t%0d want v1 t%0d", o_tagv, o_tag, t.tag);
                end
            end
            @(posedge clk); #1;
            bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
            void'(exp_tag.pop_front());
        end
    endtask

    task automatic test_wrap();
        desc_t e, t;
        int beats, seen;
        do_reset();
        renew(3);
        rcs[3] = 4'd14;
        rce[3] = 4'd1;
        bus.req_v = 4'b1000;
        bus.ur_r = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'b1000) begin
            errors++; $display("FAIL wrap_grant got %b want 1000", bus.req_r);
        end
        note_grant(3);
        @(posedge clk); #1;
        renew(3);
        bus.req_v = '0;
        @(negedge clk);
        e = exp_desc.pop_front();
        checks++;
        if (bus.ur_cstart !== e.cs || bus.ur_cend !== e.ce || bus.ur_d !== e.d) begin
            errors++;
            $display("FAIL wrap_desc got %0d %0d %h want %0d %0d %h",
                     bus.ur_cstart, bus.ur_cend, bus.ur_d, e.cs, e.ce, e.d);
        end
        seen = 0;
        t = exp_tag[0];
        beats = int'(4'(t.ce - t.cs)) + 1;
        for (int b = 0; b < beats; b++) begin
            @(posedge clk); #1;
            bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = (b == beats - 1);
            @(negedge clk);
            if (o_tagv === 1'b1 && o_tag === 2'd3) seen++;
        end
        @(posedge clk); #1;
        bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
        void'(exp_tag.pop_front());
        checks++;
        if (seen !== 4) begin
            errors++; $display("FAIL wrap_beats got %0d tagged beats want 4", seen);
        end
        @(negedge clk);
        checks++;
        if (o_tagv !== 1'b0) begin
            errors++; $display("FAIL wrap_pop got tagv %b want 0", o_tagv);
        end
    endtask

    task automatic test_err();
        desc_t t;
        int beats;
        do_reset();
        @(posedge clk); #1;
        bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = 1'b1;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL err_early got %b want 0", o_err);
        end
        @(posedge clk); #1;
        bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || o_tagv !== 1'b0) begin
            errors++; $display("FAIL err_set got err %b tagv %b want 1 0", o_err, o_tagv);
        end
        repeat (3) @(posedge clk);
        #1;
        renew(2);
        rcs[2] = 4'd0;
        rce[2] = 4'd0;
        bus.req_v = 4'b0100;
        bus.ur_r = 1'b1;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || bus.req_r !== 4'b0100) begin
            errors++; $display("FAIL err_sticky got err %b req_r %b want 1 0100", o_err, bus.req_r);
        end
        note_grant(2);
        @(posedge clk); #1;
        renew(2);
        bus.req_v = '0;
        exp_desc.delete();
        while (exp_tag.size() != 0) begin
            t = exp_tag[0];
            beats = int'(4'(t.ce - t.cs)) + 1;
            for (int b = 0; b < beats; b++) begin
                @(posedge clk); #1;
                bus.ur_ov = 1'b1; bus.ur_oacc = 1'b1; bus.ur_oed = (b == beats - 1);
                @(negedge clk);
                checks++;
                if (o_tagv !== 1'b1 || o_tag !== t.tag) begin
                    errors++; $display("FAIL err_count got v%b t%0d want v1 t%0d", o_tagv, o_tag, t.tag);
                end
            end
            @(posedge clk); #1;
            bus.ur_ov = 1'b0; bus.ur_oacc = 1'b0; bus.ur_oed = 1'b0;
            void'(exp_tag.pop_front());
        end
        @(negedge clk);
        checks++;
        if (o_tagv !== 1'b0 || o_err !== 1'b1) begin
            errors++; $display("FAIL err_after got tagv %b err %b want 0 1", o_tagv, o_err);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b want 0", o_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            renew(i); rcs[i] = 4'd0; rce[i] = 4'd3;
        end
        bus.req_v = 4'b0111;
        bus.ur_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_r !== 4'(1 << k)) begin
                errors++; $display("FAIL mid_grant%0d got %b want %b", k, bus.req_r, 4'(1 << k));
            end
            note_grant(k);
            @(posedge clk); #1;
            renew(k);
        end
        bus.req_v = '0;
        bus.ur_r = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ur_v !== 1'b1 || o_tagv !== 1'b1 || o_tag !== 2'd0) begin
            errors++; $display("FAIL mid_busy got v%b tagv%b t%0d want v1 tagv1 t0", bus.ur_v, o_tagv, o_tag);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.req_v = 4'hf;
        @(negedge clk);
        checks++;
        if (bus.req_r !== 4'h0) begin
            errors++; $display("FAIL mid_rst_req got %b want 0000", bus.req_r);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_desc.delete();
        exp_tag.delete();
        @(negedge clk);
        checks++;
        if (bus.ur_v !== 1'b0 || o_tagv !== 1'b0 || o_tag !== 2'd0) begin
            errors++; $display("FAIL mid_cleared got v%b tagv%b t%0d want v0 tagv0 t0", bus.ur_v, o_tagv, o_tag);
        end
        checks++;
        if (bus.req_r !== 4'b0001) begin
            errors++; $display("FAIL mid_first got %b want 0001", bus.req_r);
        end
        @(posedge clk); #1;
        bus.req_v = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req_v = '0;
        bus.ur_r = 1'b0;
        bus.ur_ov = 1'b0;
        bus.ur_oacc = 1'b0;
        bus.ur_oed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = '0; rcs[i] = '0; rce[i] = '0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capi_unroll_arb.md
Name: capi_unroll_arb

Overview:
- N-way round-robin arbiter and sequencer in front of the capi unroll engine.
- Each requester presents one burst descriptor: data plus beat indices cstart/cend. The block grants one descriptor at a time into the unroll engine's input.
- It tracks in-flight bursts in a tag FIFO and uses it to label every unrolled output beat with its originating requester.
- Sits between the command/DMA requesters and the shared unroll datapath.

Parameters:
- n, 4, number of requesters (2..16).
- width, 64, descriptor data width.
- cwidth, 4, beat-index width.
- tdepth, 4, in-flight burst capacity (tag FIFO entries, power of 2).
- twidth, 2, requester tag width; must satisfy 2^twidth >= n.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_v  in  n  per-requester descriptor valid.
- req_d  in  n*width  descriptor data; requester i occupies slice [i*width:(i+1)*width-1].
- req_cstart  in  n*cwidth  first beat index, same slicing.
- req_cend  in  n*cwidth  last beat index, same slicing.
- req_r  out  n  per-requester accept; at most one bit set per cycle.
- ur_v  out  1  descriptor valid to the unroll engine (its dinv).
- ur_d  out  width  descriptor data (its din).
- ur_cstart  out  cwidth  to its cstart.
- ur_cend  out  cwidth  to its cend.
- ur_r  in  1  engine accept (its din_acc).
- ur_ov  in  1  engine output valid (its doutv), monitored only.
- ur_oed  in  1  engine last-beat flag (its dout_ed), monitored only.
- ur_oacc  in  1  downstream accept of the engine output (its dout_acc), monitored only.
- o_tag  out  twidth  requester tag of the burst currently at the engine output.
- o_tagv  out  1  o_tag valid (FIFO non-empty).
- o_err  out  1  sticky protocol error.

Behaviour:
- Output register: one-entry descriptor register {ur_d, ur_cstart, ur_cend, ur_v}.
  - Loads when (~ur_v | ur_r) and a grant is issued.
  - On ur_v & ur_r with no grant that cycle, ur_v clears next cycle.
- Grant conditions: grant issued iff (~ur_v | ur_r) & |req_v & ~fifo_full.
- fifo_full means count == tdepth, evaluated before any same-cycle pop. A pop in the same cycle does not free a slot for a grant (conservative, no comb path from ur_oacc to req_r).
- Round robin:
  - ptr (twidth bits) names the highest-priority requester; scan ptr, ptr+1, ... mod n.
  - On grant to requester g: ptr <= (g+1) mod n. ptr holds when there is no grant.
  - req_r[g]=1 in the grant cycle only.
  - Requester valid/data must hold until accepted; the block never reads a requester's data without a grant.
- Latency: descriptor accepted at req_r in cycle T appears on ur_v in T+1. Full throughput, one descriptor per cycle, when ur_r=1 continuously.
- Tag FIFO:
  - Push g on grant.
  - Pop on ur_ov & ur_oacc & ur_oed.
  - Simultaneous push and pop: count unchanged, both take effect.
  - o_tag = head entry; o_tagv = count != 0.
  - Pointers wrap modulo tdepth.
- Beat count per descriptor is ((cend - cstart) mod 2^cwidth) + 1; cstart > cend wraps, cstart == cend is one beat. Passed through unmodified; the block does not count beats.
- o_err: set (sticky until reset) when a pop condition occurs with count == 0. The pop is then ignored and count stays 0.
- Reset values: req_r=0, ur_v=0, ur_d/ur_cstart/ur_cend=0, ptr=0, FIFO count=0, o_tagv=0, o_tag=0, o_err=0.
- Reset mid-burst: all state discarded next cycle. The engine is assumed reset by the same reset, so no tags are orphaned.
- n not power of 2: ptr wrap uses explicit compare with n-1; tags >= n are never produced.

Decomposition:
- Shared package: tag width function (clog2), FIFO depth constant, descriptor field offsets for the req_* slicing.
- One natural sub-module: capi_unroll_tagfifo, a tdepth x twidth synchronous FIFO with push/pop/count/full/empty and a registered head.
- Round-robin scan stays inline.

Test Plan:
- Single requester 1, cstart=2 cend=5, ur_r=1 -> req_r[1] in T, ur_v in T+1. o_tag=1 held for 4 beats; FIFO pops on the beat with ur_oed, o_tagv drops.
- All 4 requesters valid continuously, ur_r=1 -> grants 0,1,2,3,0,... one per cycle until FIFO full. Grants resume the cycle after the first pop is registered.
- ur_r=0 with ur_v=1 and req_v=4'b0110 -> no req_r, ur_d stable. When ur_r rises, requester 1 is granted in that same cycle.
- cstart=14 cend=1 (cwidth=4) -> 4 beats at engine output, single tag, one pop.
- Pop condition (ur_ov & ur_oacc & ur_oed) with empty FIFO -> o_err=1 next cycle and stays 1 until reset; count stays 0.
- Reset asserted with 3 bursts in flight and ur_v=1 -> next cycle ur_v=0, o_tagv=0, ptr=0; the first grant after reset goes to requester 0 when all are valid.
